trace_capture_readout: RTL and testbench
========================================

// Module: trace_capture_readout
// PURPOSE
//  On-chip trace buffer: records a PROBE_W-bit probe vector (video-rotate debug signals:
//  10-bit coord, 1-bit valid, 15-bit addr) into BRAM around a trigger condition.
//  Replays the captured window oldest-first as a byte stream (valid/ready) for a UART/host link.
//  Read-back counterpart to the vendor capture core; fully vendor-independent.
// PARAMETERS
//  PROBE_W   26    width of captured probe vector
//  DEPTH     1024  samples in buffer (power of 2)
//  PRE_TRIG  256   samples kept before trigger (< DEPTH)
// PORTS
//  clk          in   1        sole clock
//  rst          in   1        synchronous reset, active-high
//  arm          in   1        1-cycle pulse: start capture (honoured in IDLE/DONE only)
//  abort        in   1        return to IDLE from any state
//  probe        in   PROBE_W  sample data
//  probe_valid  in   1        sample qualifier; only qualified samples are stored
//  trig_mask    in   PROBE_W  bits compared for trigger
//  trig_value   in   PROBE_W  trigger match value
//  tx_data      out  8        readout byte
//  tx_valid     out  1        tx_data valid
//  tx_ready     in   1        sink accepts byte when tx_valid&tx_ready
//  busy         out  1        state != IDLE/DONE
//  triggered    out  1        trigger seen in current capture; held until next arm/abort
//  done         out  1        high in DONE state
// BEHAVIOUR
//  Reset: state IDLE; tx_data=0, tx_valid=0, busy=0, triggered=0, done=0; counters/ptrs=0.
//  FSM: IDLE -arm-> PREFILL; PREFILL: store qualified samples, after PRE_TRIG stored -> ARMED;
//   ARMED: ring-write; trigger = probe_valid & ((probe^trig_value)&trig_mask)==0 -> POST;
//   trigger sample is stored, its address latched as trig_addr; POST: store until
//   DEPTH-PRE_TRIG samples incl. trigger sample -> DUMP; DUMP: emit stream -> DONE.
//  Trigger during PREFILL ignored. trig_mask=0 -> first qualified sample in ARMED triggers.
//  Write ptr wraps mod DEPTH. Readout start addr = (trig_addr - PRE_TRIG) mod DEPTH.
//  Stream: header 0xA5, then DEPTH records, each BPS=ceil(PROBE_W/8) bytes, LS byte first;
//   unused MSBs of last byte are 0. Trailer 0x5A. Total bytes = DEPTH*BPS + 2.
//  tx handshake: once tx_valid rises, tx_data stable and tx_valid held until tx_ready;
//   tx_ready with tx_valid=0 ignored. RAM read latency 1 clk; prefetch so back-to-back
//   bytes at 1/clk sustained with tx_ready held high (no gaps after header).
//  DONE: done=1; arm restarts capture (PREFILL), clears triggered/done.
//  arm while busy ignored. abort same cycle as arm: abort wins. abort mid-DUMP: tx_valid
//   drops next cycle (byte in flight discarded), state IDLE.
//  rst mid-operation: identical to power-on reset; partial stream is not resumed.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: 16-bit free-running clk counter stored with each sample;
//   each record = 2 timestamp bytes (LS first) then probe bytes; total DEPTH*(BPS+2)+2.
//   Counter wraps at 0xFFFF, cleared on rst and arm.
//  Undefined: no counter, no extra RAM width, records are probe bytes only.
// STRUCTURE
//  trace_pkg: state enum {IDLE,PREFILL,ARMED,POST,DUMP,DONE}; HDR_BYTE=8'hA5,
//   TRL_BYTE=8'h5A; function bytes_per_sample(w).
//  Sub-module trace_ram: simple dual-port, 1 write port, 1 read port, 1-clk read latency,
//   width PROBE_W (+16 with TRACE_TIMESTAMP_EN), depth DEPTH; infers BRAM.
//  Top: FSM, write/read ptrs, byte serializer.
// TESTING (DEPTH=16, PRE_TRIG=4, PROBE_W=26)
//  1 arm; probe=0..39 valid each clk; mask=all1, value=20 -> bytes A5, samples 16..31 (4B each,
//    LS first), 5A; 66 bytes total; triggered=1, done=1.
//  2 trigger value=2 appears during PREFILL (only samples 0..3 seen) -> ignored; next match
//    after ARMED used; start addr = trig_addr-4 mod 16 verified across wrap.
//  3 tx_ready random 30% during DUMP -> tx_data never changes while tx_valid&!tx_ready;
//    stream identical to scenario 1; tx_ready=1 constant -> 66 bytes in 66 consecutive beats.
//  4 probe_valid toggling every other clk -> only qualified samples stored; gaps absent.
//  5 abort at byte 10 of DUMP -> tx_valid=0 next clk, busy=0; rst mid-POST -> all outputs 0.
//  6 TRACE_TIMESTAMP_EN: same stim as 1 -> 98 bytes; consecutive timestamps differ by 1.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture/readout block.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    DUMP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SQ_HDR,
    SQ_REC,
    SQ_TRL,
    SQ_END
  } seq_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] TRL_BYTE = 8'h5A;

  function automatic int bytes_per_sample(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store, registered read (1 clk latency).
module trace_ram #(
  parameter int W     = 26,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/trace_capture_readout.sv
// Trace buffer: captures a probe window around a trigger, replays it as bytes.
// Define TRACE_TIMESTAMP_EN to store a 16-bit cycle stamp with each sample.
module trace_capture_readout
  import trace_pkg::*;
#(
  parameter int PROBE_W  = 26,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic [PROBE_W-1:0] probe,
  input  logic               probe_valid,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               triggered,
  output logic               done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int BPS = bytes_per_sample(PROBE_W);
`ifdef TRACE_TIMESTAMP_EN
  localparam int RW = PROBE_W + 16;
  localparam int RB = BPS + 2;
`else
  localparam int RW = PROBE_W;
  localparam int RB = BPS;
`endif
  localparam int BW = (RB > 1) ? $clog2(RB) : 1;

  localparam logic [AW:0]   PRE_M1   = (AW+1)'(PRE_TRIG - 1);
  localparam logic [AW:0]   POST_M1  = (AW+1)'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] A_ONE    = AW'(1);
  localparam logic [AW-1:0] PRE_A    = AW'(PRE_TRIG);
  localparam logic [AW-1:0] REC_LAST = AW'(DEPTH - 1);
  localparam logic [BW-1:0] B_ONE    = BW'(1);
  localparam logic [BW-1:0] B_LAST   = BW'(RB - 1);

  state_e          state_q, state_d;
  seq_e            seq_q, seq_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   trig_addr_q, trig_addr_d;
  logic [AW-1:0]   rec_q, rec_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [BW-1:0]   b_q, b_d;
  logic [RW-1:0]   sh_q, sh_d;
  logic            trig_q, trig_d;
  logic            txv_q, txv_d;
  logic [7:0]      txd_q, txd_d;

  logic            we, re, match, load, arm_ok;
  logic [AW-1:0]   raddr;
  logic [RW-1:0]   wdata, rdata;
  logic [RB*8-1:0] pad;

  assign match  = ((probe ^ trig_value) & trig_mask) == '0;
  assign load   = !txv_q || tx_ready;
  assign arm_ok = arm && !abort && (state_q == IDLE || state_q == DONE);
  // byte 0 of a record comes straight from the RAM, later bytes from sh_q
  assign pad    = (RB*8)'((b_q == '0) ? rdata : sh_q);

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;

  assign ts_d  = arm_ok ? 16'd0 : ts_q + 16'd1;
  assign wdata = {probe, ts_q};

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`else
  assign wdata = probe;
`endif

  trace_ram #(
    .W     (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    rec_d       = rec_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    sh_d        = sh_q;
    trig_d      = trig_q;
    txv_d       = txv_q;
    txd_d       = txd_q;
    we          = 1'b0;
    re          = 1'b0;
    raddr       = rd_ptr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (arm_ok) begin
          state_d  = (PRE_TRIG == 0) ? ARMED : PREFILL;
          wr_ptr_d = '0;
          cnt_d    = '0;
          trig_d   = 1'b0;
        end
      end
      PREFILL: begin
        if (probe_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + A_ONE;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == PRE_M1) begin
            state_d = ARMED;
            cnt_d   = '0;
          end
        end
      end
      ARMED: begin
        if (probe_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + A_ONE;
          if (match) begin
            trig_addr_d = wr_ptr_q;
            trig_d      = 1'b1;
            cnt_d       = CNT_ONE;
            seq_d       = SQ_HDR;
            state_d     = (DEPTH - PRE_TRIG == 1) ? DUMP : POST;
          end
        end
      end
      POST: begin
        if (probe_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + A_ONE;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == POST_M1) begin
            state_d = DUMP;
            seq_d   = SQ_HDR;
          end
        end
      end
      DUMP: begin
        unique case (seq_q)
          SQ_HDR: begin
            // first record is fetched while the header goes out
            txd_d    = HDR_BYTE;
            txv_d    = 1'b1;
            re       = 1'b1;
            raddr    = trig_addr_q - PRE_A;
            rd_ptr_d = raddr + A_ONE;
            rec_d    = '0;
            b_d      = '0;
            seq_d    = SQ_REC;
          end
          SQ_REC: begin
            if (load) begin
              txd_d = pad[{b_q, 3'b000} +: 8];
              txv_d = 1'b1;
              if (b_q == '0) begin
                sh_d = rdata;
                if (rec_q != REC_LAST) begin
                  re       = 1'b1;
                  rd_ptr_d = rd_ptr_q + A_ONE;
                end
              end
              if (b_q == B_LAST) begin
                b_d   = '0;
                rec_d = rec_q + A_ONE;
                if (rec_q == REC_LAST) seq_d = SQ_TRL;
              end else begin
                b_d = b_q + B_ONE;
              end
            end
          end
          SQ_TRL: begin
            if (load) begin
              txd_d = TRL_BYTE;
              txv_d = 1'b1;
              seq_d = SQ_END;
            end
          end
          SQ_END: begin
            if (tx_ready) begin
              txv_d   = 1'b0;
              state_d = DONE;
            end
          end
          default: seq_d = SQ_HDR;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      txv_d   = 1'b0;
      trig_d  = 1'b0;
      we      = 1'b0;
      re      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      seq_q       <= SQ_HDR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      rec_q       <= '0;
      cnt_q       <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      trig_q      <= 1'b0;
      txv_q       <= 1'b0;
      txd_q       <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      rec_q       <= rec_d;
      cnt_q       <= cnt_d;
      b_q         <= b_d;
      sh_q        <= sh_d;
      trig_q      <= trig_d;
      txv_q       <= txv_d;
      txd_q       <= txd_d;
    end
  end

  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;
  assign triggered = trig_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_trace_capture_readout.sv
// Bench for trace_capture_readout: directed and random captures vs a window model.
// Honours TRACE_TIMESTAMP_EN for the record layout.
module tb_trace_capture_readout;

  localparam int PW    = 26;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int BPS   = (PW + 7) / 8;
`ifdef TRACE_TIMESTAMP_EN
  localparam int RB = BPS + 2;
`else
  localparam int RB = BPS;
`endif
  localparam int TOT  = DEPTH * RB + 2;
  localparam int NMAX = 200;

  logic          clk = 1'b0;
  logic          rst, arm, abort, pv, tx_ready;
  logic          tx_valid, busy, triggered, done;
  logic [PW-1:0] probe, tm, tv;
  logic [7:0]    tx_data;

  int checks = 0;
  int fails  = 0;

  logic [PW-1:0] pr  [NMAX];
  bit            pvs [NMAX];
  int            ns;
  byte unsigned  obs[$];
  byte unsigned  exp[$];

  trace_capture_readout #(
    .PROBE_W  (PW),
    .DEPTH    (DEPTH),
    .PRE_TRIG (PRE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .abort       (abort),
    .probe       (probe),
    .probe_valid (pv),
    .trig_mask   (tm),
    .trig_value  (tv),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected stream: header, the DEPTH stored samples starting PRE
  // before the first trigger match seen after prefill, trailer.
  task automatic model();
    logic [PW-1:0] st[$];
    int            sc[$];
    int            t;
    logic [31:0]   p;
    exp.delete();
    for (int i = 0; i < ns; i++)
      if (pvs[i]) begin
        st.push_back(pr[i]);
        sc.push_back(i);
      end
    t = -1;
    for (int i = PRE; i < st.size(); i++)
      if (t < 0 && ((st[i] ^ tv) & tm) == '0) t = i;
    if (t < PRE || t - PRE + DEPTH > st.size()) begin
      $display("FAIL stimulus has no usable trigger window");
      $fatal(1);
    end
    exp.push_back(8'hA5);
    for (int r = 0; r < DEPTH; r++) begin
      int k;
      k = t - PRE + r;
`ifdef TRACE_TIMESTAMP_EN
      exp.push_back(8'(sc[k]));
      exp.push_back(8'(sc[k] >> 8));
`endif
      p = 32'(st[k]);
      for (int j = 0; j < BPS; j++) exp.push_back(p[8*j +: 8]);
    end
    exp.push_back(8'h5A);
  endtask

  task automatic capture(input int rdy_pct, input int abort_at,
                         input int arm_at, input string nm);
    int         first_c, last_c, lim;
    bit         pend, ab, fin;
    logic [7:0] pd;
    first_c = -1;
    last_c  = -1;
    pend    = 0;
    ab      = 0;
    fin     = 0;
    pd      = '0;
    model();
    obs.delete();
    @(negedge clk);
    arm = 1'b1;
    lim = ns + TOT * 12 + 50;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      arm   = (c == arm_at);
      abort = 1'b0;
      if (fin) begin
        chk({nm, "_done"}, done, 1);
        chk({nm, "_trig"}, triggered, 1);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_txv_end"}, tx_valid, 0);
        chk({nm, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < obs.size() && i < exp.size(); i++)
          chk($sformatf("%s_b%0d", nm, i), obs[i], exp[i]);
        if (rdy_pct >= 100)
          chk({nm, "_beats"}, last_c - first_c + 1, TOT);
        return;
      end
      if (ab) begin
        chk({nm, "_abort_txv"}, tx_valid, 0);
        chk({nm, "_abort_busy"}, busy, 0);
        chk({nm, "_abort_done"}, done, 0);
        for (int i = 0; i < obs.size(); i++)
          chk($sformatf("%s_b%0d", nm, i), obs[i], exp[i]);
        return;
      end
      if (c == 0) begin
        chk({nm, "_busy_arm"}, busy, 1);
        chk({nm, "_done_arm"}, done, 0);
        chk({nm, "_trig_arm"}, triggered, 0);
      end
      if (pend) begin
        chk({nm, "_hold_v"}, tx_valid, 1);
        chk({nm, "_hold_d"}, tx_data, pd);
      end
      tx_ready = ($urandom_range(99) < rdy_pct);
      pend = 0;
      if (tx_valid) begin
        if (first_c < 0) first_c = c;
        if (tx_ready) begin
          obs.push_back(tx_data);
          last_c = c;
        end else begin
          pend = 1;
          pd   = tx_data;
        end
      end
      if (abort_at >= 0 && obs.size() == abort_at && !ab) begin
        abort = 1'b1;
        ab    = 1;
      end
      if (obs.size() == TOT) fin = 1;
      probe = (c < ns) ? pr[c] : '0;
      pv    = (c < ns) ? pvs[c] : 1'b0;
    end
    chk({nm, "_timeout"}, obs.size(), TOT);
  endtask

  task automatic count_stim(input int n);
    ns = n;
    for (int c = 0; c < n; c++) begin
      pr[c]  = PW'(c);
      pvs[c] = 1'b1;
    end
  endtask

  initial begin
    int tsa, tsb, pos, want;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; pv = 1'b0;
    probe = '0; tm = '0; tv = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    count_stim(40);
    tm = '1; tv = PW'(20);
    capture(100, -1, -1, "s1");
`ifdef TRACE_TIMESTAMP_EN
    if (obs.size() == TOT)
      for (int r = 1; r < DEPTH; r++) begin
        tsa = {obs[2+(r-1)*RB], obs[1+(r-1)*RB]};
        tsb = {obs[2+r*RB], obs[1+r*RB]};
        chk($sformatf("ts_step%0d", r), tsb - tsa, 1);
      end
`endif

    count_stim(40);
    for (int c = 0; c < 40; c++) pr[c] = PW'(c % 16);
    tv = PW'(2);
    capture(100, -1, -1, "s2");

    count_stim(40);
    tv = PW'(20);
    capture(30, -1, -1, "s3");

    count_stim(80);
    for (int c = 0; c < 80; c++) pvs[c] = c[0];
    tv = PW'(41);
    capture(100, -1, 8, "s4");

    ns = 120;
    for (int c = 0; c < ns; c++) begin
      pr[c]  = PW'($urandom);
      pvs[c] = ($urandom_range(99) < 70);
    end
    tm = '0;
    tv = PW'($urandom);
    capture(60, -1, -1, "s_m0");

    for (int k = 0; k < 3; k++) begin
      ns = 150;
      for (int c = 0; c < ns; c++) begin
        pr[c]  = PW'($urandom);
        pvs[c] = ($urandom_range(99) < 75);
      end
      tm   = PW'($urandom) & PW'(32'hF << $urandom_range(20));
      tv   = PW'($urandom);
      want = PRE + $urandom_range(20);
      pos  = 0;
      for (int c = 0; c < ns; c++)
        if (pvs[c]) begin
          if (pos == want) pr[c] = (pr[c] & ~tm) | (tv & tm);
          pos++;
        end
      capture($urandom_range(100, 30), -1, -1,
              $sformatf("r%0d", k));
    end

    count_stim(40);
    tm = '1; tv = PW'(20);
    capture(100, 10, -1, "s5");

    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    chk("armabort_busy", busy, 0);
    chk("armabort_done", done, 0);

    @(negedge clk);
    arm = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      arm   = 1'b0;
      probe = pr[c];
      pv    = 1'b1;
    end
    @(negedge clk);
    pv = 1'b0;
    chk("post_trig", triggered, 1);
    chk("post_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_txv", tx_valid, 0);
    chk("mrst_txd", tx_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_trig", triggered, 0);
    chk("mrst_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
